// File: rtl/keygen_sequencer_if.sv
// Bus bundle between the key-generation sequencer, its shared RNG and the key store.
// The DUT uses the slave modport; the surrounding control/RNG/store side uses master.
interface keygen_sequencer_if #(
  parameter int ROWS   = 2,
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int COEF_W = 5
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  // Handshakes: start is a one-cycle request honoured only in IDLE; rng_en is a
  // one-cycle draw strobe whose rng_data answer is valid the following cycle;
  // key_we is a fire-and-forget write strobe (the key store has no back-pressure).
  logic              start;
  logic              abort;
  logic              rng_en;
  logic [DATA_W-1:0] rng_data;
  logic              key_we;
  logic [ROW_W-1:0]  key_row;
  logic [COL_W-1:0]  key_col;
  logic [COEF_W-1:0] key_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              key_valid;
  logic [15:0]       reject_cnt;

  modport slave (
    input  start, abort, rng_data,
    output rng_en, key_we, key_row, key_col, key_data,
           busy, done, err, key_valid, reject_cnt
  );

  modport master (
    output start, abort, rng_data,
    input  rng_en, key_we, key_row, key_col, key_data,
           busy, done, err, key_valid, reject_cnt
  );
endinterface

// File: rtl/keygen_sequencer.sv
// Drives one shared RNG to fill a ROWS x COLS key matrix by rejection sampling,
// writing accepted coefficients row-major into an external key store.
module keygen_sequencer #(
  parameter int ROWS    = 2,
  parameter int COLS    = 4,
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 5,
  parameter int Q       = 17,
  parameter int MAX_REJ = 255
) (
  input  logic                clk,
  input  logic                rst,
  keygen_sequencer_if.slave   bus,
  output logic [1:0]          state_o
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [COEF_W:0]  Q_L       = (COEF_W+1)'(Q);
  localparam logic [15:0]      MAX_REJ_L = 16'(MAX_REJ);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);

  logic [1:0]        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [15:0]       coef_rej_q, coef_rej_d;
  logic [15:0]       reject_cnt_q, reject_cnt_d;
  logic              err_q, err_d;
  logic              key_valid_q, key_valid_d;

  logic [COEF_W-1:0] cand;
  logic              accept;
  logic              last_idx;
  logic [15:0]       coef_rej_inc;
  logic              unused_rng_hi;

  // Only the low COEF_W bits of each RNG word form the candidate.
  assign cand          = bus.rng_data[COEF_W-1:0];
  assign unused_rng_hi = ^bus.rng_data[DATA_W-1:COEF_W];
  assign accept        = ({1'b0, cand} < Q_L);
  assign last_idx      = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign coef_rej_inc  = coef_rej_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    coef_rej_d   = coef_rej_q;
    reject_cnt_d = reject_cnt_q;
    err_d        = err_q;
    key_valid_d  = key_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_REQ;
          row_d        = '0;
          col_d        = '0;
          coef_rej_d   = '0;
          reject_cnt_d = '0;
          err_d        = 1'b0;
          key_valid_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (bus.abort) begin
          state_d     = S_IDLE;
          key_valid_d = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Abort outranks a same-cycle accept so a cancelled run never writes.
        if (bus.abort) begin
          state_d     = S_IDLE;
          key_valid_d = 1'b0;
        end else if (accept) begin
          coef_rej_d = '0;
          if (last_idx) begin
            state_d     = S_DONE;
            key_valid_d = 1'b1;
          end else begin
            state_d = S_REQ;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end else begin
          reject_cnt_d = (reject_cnt_q == 16'hFFFF) ? reject_cnt_q : reject_cnt_q + 16'd1;
          coef_rej_d   = coef_rej_inc;
          if (coef_rej_inc == MAX_REJ_L) begin
            state_d     = S_DONE;
            err_d       = 1'b1;
            key_valid_d = 1'b0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      coef_rej_q   <= '0;
      reject_cnt_q <= '0;
      err_q        <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      coef_rej_q   <= coef_rej_d;
      reject_cnt_q <= reject_cnt_d;
      err_q        <= err_d;
      key_valid_q  <= key_valid_d;
    end
  end

  assign bus.rng_en     = (state_q == S_REQ);
  assign bus.key_we     = (state_q == S_WAIT) && accept && !bus.abort;
  assign bus.key_row    = row_q;
  assign bus.key_col    = col_q;
  assign bus.key_data   = cand;
  assign bus.busy       = (state_q == S_REQ) || (state_q == S_WAIT);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.reject_cnt = reject_cnt_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_keygen_sequencer.sv
// Directed bench for keygen_sequencer: table-driven key runs plus hand-written
// abort, reset and start/abort-collision sequences.
module tb_keygen_sequencer;
  localparam int ROWS = 2, COLS = 4, DATA_W = 32, COEF_W = 5, Q = 17, MAX_REJ = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state;

  always #5 clk = ~clk;

  keygen_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

  keygen_sequencer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .COEF_W(COEF_W),
                     .Q(Q), .MAX_REJ(MAX_REJ)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state)
  );

  typedef struct {
    int          run;
    logic [31:0] rng;
    logic        acc;
    logic [4:0]  data;
  } vec_t;

  vec_t        tbl[19];
  logic [31:0] rng_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rng_cnt = 0;
  int          done_cnt = 0;
  int          n_draws;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One negedge: RNG model answers draws, write monitor and done counter sample.
  task automatic tick();
    @(negedge clk);
    if (bus.key_we) got_q.push_back({bus.key_row, bus.key_col, bus.key_data});
    if (bus.done) done_cnt++;
    if (bus.rng_en) begin
      rng_cnt++;
      bus.rng_data = (rng_q.size() > 0) ? rng_q.pop_front() : 32'd20;
    end
  endtask

  task automatic build(input int id);
    logic [0:0] rr;
    logic [1:0] cc;
    rr = '0;
    cc = '0;
    rng_q.delete();
    exp_q.delete();
    got_q.delete();
    n_draws = 0;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].run == id) begin
        rng_q.push_back(tbl[i].rng);
        n_draws++;
        if (tbl[i].acc) begin
          exp_q.push_back({rr, cc, tbl[i].data});
          if (cc == 2'd3) begin
            cc = 2'd0;
            rr = rr + 1'b1;
          end else begin
            cc = cc + 2'd1;
          end
        end
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic run_key(input string tag, input int id, input bit spam, input bit both,
                         input int exp_rej, input bit exp_err, input int exp_draws,
                         input bit chk_lat);
    int d0, r0, n;
    build(id);
    d0 = done_cnt;
    r0 = rng_cnt;
    bus.start = 1'b1;
    bus.abort = both;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check({tag, "_start_to_req"}, state, S_REQ);
    check({tag, "_err_cleared"}, bus.err, 1'b0);
    n = 1;
    while (done_cnt == d0 && n < 200) begin
      bus.start = spam && (n % 4 == 2);
      tick();
      n++;
    end
    bus.start = 1'b0;
    if (done_cnt == d0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    if (chk_lat) check({tag, "_done_latency"}, n, 17);
    check({tag, "_busy_in_done"}, bus.busy, 1'b0);
    check({tag, "_key_valid"}, bus.key_valid, !exp_err);
    check({tag, "_err"}, bus.err, exp_err);
    check({tag, "_reject_cnt"}, bus.reject_cnt, exp_rej);
    check({tag, "_draws"}, rng_cnt - r0, exp_draws);
    tick();
    check({tag, "_done_one_cycle"}, bus.done, 1'b0);
    check({tag, "_back_to_idle"}, state, S_IDLE);
    check({tag, "_err_sticky"}, bus.err, exp_err);
    compare_writes(tag);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
    check({tag, "_key_valid"}, bus.key_valid, 1'b0);
    check({tag, "_reject_cnt"}, bus.reject_cnt, 16'd0);
    check({tag, "_rng_en"}, bus.rng_en, 1'b0);
    check({tag, "_key_we"}, bus.key_we, 1'b0);
  endtask

  initial begin
    int d0, r0, n;
    // Run 0: eight accepts. Run 1: rejects of 17, 31 and 0x31 (LSBs 17) mixed with
    // accepts whose upper bits are set (0xFFFFFFE5 -> 5, 0xFFFFFFF0 -> 16).
    tbl[0]  = '{0, 32'd3,          1'b1, 5'd3};
    tbl[1]  = '{0, 32'd9,          1'b1, 5'd9};
    tbl[2]  = '{0, 32'd16,         1'b1, 5'd16};
    tbl[3]  = '{0, 32'd0,          1'b1, 5'd0};
    tbl[4]  = '{0, 32'd1,          1'b1, 5'd1};
    tbl[5]  = '{0, 32'd2,          1'b1, 5'd2};
    tbl[6]  = '{0, 32'd5,          1'b1, 5'd5};
    tbl[7]  = '{0, 32'd7,          1'b1, 5'd7};
    tbl[8]  = '{1, 32'd17,         1'b0, 5'd0};
    tbl[9]  = '{1, 32'd31,         1'b0, 5'd0};
    tbl[10] = '{1, 32'd4,          1'b1, 5'd4};
    tbl[11] = '{1, 32'hFFFF_FFE5,  1'b1, 5'd5};
    tbl[12] = '{1, 32'd10,         1'b1, 5'd10};
    tbl[13] = '{1, 32'd0,          1'b1, 5'd0};
    tbl[14] = '{1, 32'hFFFF_FFF0,  1'b1, 5'd16};
    tbl[15] = '{1, 32'd3,          1'b1, 5'd3};
    tbl[16] = '{1, 32'h0000_0031,  1'b0, 5'd0};
    tbl[17] = '{1, 32'd12,         1'b1, 5'd12};
    tbl[18] = '{1, 32'd1,          1'b1, 5'd1};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_zero("reset");

    run_key("basic",   0, 1'b0, 1'b0, 0, 1'b0, 8,  1'b1);
    run_key("rejects", 1, 1'b0, 1'b0, 3, 1'b0, 11, 1'b0);
    run_key("maxrej",  2, 1'b0, 1'b0, 3, 1'b1, 3,  1'b0);
    run_key("after_err", 0, 1'b0, 1'b0, 0, 1'b0, 8, 1'b1);

    // Abort in WAIT of draw 4 while the RNG offers an acceptable value.
    build(0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    d0 = done_cnt;
    r0 = rng_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (rng_cnt - r0 < 4 && n < 100) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1 bus.abort = 1'b1;
    #1;
    check("abort_in_wait_state", state, S_WAIT);
    check("abort_forces_no_we", bus.key_we, 1'b0);
    tick();
    tick();
    bus.abort = 1'b0;
    check("abort_state_idle", state, S_IDLE);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_key_valid", bus.key_valid, 1'b0);
    tick();
    tick();
    check("abort_no_done", done_cnt, d0);
    compare_writes("abort");
    run_key("after_abort", 0, 1'b0, 1'b0, 0, 1'b0, 8, 1'b1);

    // Start pulses during a run must not restart or extend it.
    run_key("spam", 0, 1'b1, 1'b0, 0, 1'b0, 8, 1'b1);

    // Reset after a completed run clears key_valid; reset mid-run discards the run.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_key_valid", bus.key_valid, 1'b0);
    build(0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    d0 = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrun_rst");
    for (int i = 0; i < 4; i++) tick();
    check("midrun_rst_no_done", done_cnt, d0);
    compare_writes("midrun_rst");
    run_key("after_rst", 0, 1'b0, 1'b0, 0, 1'b0, 8, 1'b1);

    // start and abort together in IDLE: start wins.
    run_key("start_abort", 0, 1'b0, 1'b1, 0, 1'b0, 8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
